// File: rtl/fastpath_pkg.sv
// Shared types and widths for the fastpath predictor and its in-flight queue.
// Everything the queue stores and replays is described here.
package fastpath_pkg;

    localparam int PC_WIDTH         = 64;
    localparam int GHR_WIDTH        = 32;
    localparam int IDX_WIDTH        = 6;
    localparam int SV_WIDTH         = GHR_WIDTH * IDX_WIDTH;
    localparam int WEIGHT_ENTRY_NUM = 1 << IDX_WIDTH;

    typedef struct packed {
        logic [PC_WIDTH-1:0]  pc;
        logic [GHR_WIDTH-1:0] h;
        logic [SV_WIDTH-1:0]  sv;
        logic                 prediction;
    } pred_entry_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]  last_pc;
        logic [GHR_WIDTH-1:0] last_h;
        logic [SV_WIDTH-1:0]  last_v;
        logic                 last_prediction;
        logic                 br_outcome;
    } train_bundle_t;

    function automatic logic is_mispredict(input pred_entry_t e,
                                           input logic taken);
        return e.prediction != taken;
    endfunction

endpackage

// File: rtl/pred_entry_ram.sv
// Entry storage for the prediction queue: one write port, async read at head.
// Contents are never reset; validity is tracked by the queue pointers.
module pred_entry_ram
    import fastpath_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  pred_entry_t       i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output pred_entry_t       o_rdata
);

    pred_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fastpath_pred_queue.sv
// In-flight prediction queue: holds predictions in order and replays the
// head entry as a registered training bundle when its branch resolves.
module fastpath_pred_queue
    import fastpath_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 make_prediction,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [GHR_WIDTH-1:0] h,
    input  logic [SV_WIDTH-1:0]  sv,
    input  logic                 prediction,
    input  logic                 resolve_valid,
    input  logic                 resolve_taken,
    output logic                 update,
    output logic [PC_WIDTH-1:0]  last_pc,
    output logic [GHR_WIDTH-1:0] last_h,
    output logic [SV_WIDTH-1:0]  last_v,
    output logic                 last_prediction,
    output logic                 br_outcome,
    output logic                 mispredict,
    output logic                 full,
    output logic                 empty,
    output logic [CW-1:0]        count,
    output logic [15:0]          drop_cnt,
    output logic                 resolve_err
);

    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_drop_cnt;
    logic           r_update;
    logic           r_mispredict;
    logic           r_resolve_err;
    train_bundle_t  r_train;

    pred_entry_t    w_head_entry;
    pred_entry_t    w_new_entry;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_mis;
    logic           w_push;
    logic           w_drop;
    logic           w_err;
    logic [PW-1:0]  w_head_nxt;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    assign w_new_entry = '{pc: pc, h: h, sv: sv, prediction: prediction};

    assign w_pop  = resolve_valid && !w_empty;
    assign w_err  = resolve_valid && w_empty;
    assign w_mis  = w_pop && is_mispredict(w_head_entry, resolve_taken);

    // A flush squashes the same-cycle push outright; it is not a drop.
    assign w_push = make_prediction && !w_mis && (!w_full || w_pop);
    assign w_drop = make_prediction && w_full && !w_pop;

    assign w_head_nxt = r_head + PW'(1);

    pred_entry_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_tail),
        .i_wdata (w_new_entry),
        .i_raddr (r_head),
        .o_rdata (w_head_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mis) begin
            r_head  <= w_head_nxt;
            r_tail  <= w_head_nxt;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_update      <= 1'b0;
            r_mispredict  <= 1'b0;
            r_resolve_err <= 1'b0;
            r_train       <= '0;
        end else begin
            r_update      <= w_pop;
            r_mispredict  <= w_mis;
            r_resolve_err <= w_err;
            if (w_pop) begin
                r_train.last_pc         <= w_head_entry.pc;
                r_train.last_h          <= w_head_entry.h;
                r_train.last_v          <= w_head_entry.sv;
                r_train.last_prediction <= w_head_entry.prediction;
                r_train.br_outcome      <= resolve_taken;
            end
        end
    end

    assign update          = r_update;
    assign mispredict      = r_mispredict;
    assign resolve_err     = r_resolve_err;
    assign last_pc         = r_train.last_pc;
    assign last_h          = r_train.last_h;
    assign last_v          = r_train.last_v;
    assign last_prediction = r_train.last_prediction;
    assign br_outcome      = r_train.br_outcome;
    assign full            = w_full;
    assign empty           = w_empty;
    assign count           = r_count;
    assign drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_fastpath_pred_queue.sv
// Directed bench for fastpath_pred_queue.
// Expected values are hand-derived or taken from a small in-order model.
module tb_fastpath_pred_queue;
    import fastpath_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 make_prediction;
    logic [PC_WIDTH-1:0]  pc;
    logic [GHR_WIDTH-1:0] h;
    logic [SV_WIDTH-1:0]  sv;
    logic                 prediction;
    logic                 resolve_valid;
    logic                 resolve_taken;
    logic                 update;
    logic [PC_WIDTH-1:0]  last_pc;
    logic [GHR_WIDTH-1:0] last_h;
    logic [SV_WIDTH-1:0]  last_v;
    logic                 last_prediction;
    logic                 br_outcome;
    logic                 mispredict;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic [15:0]          drop_cnt;
    logic                 resolve_err;

    int n_cmp = 0;
    int n_err = 0;

    fastpath_pred_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .make_prediction (make_prediction),
        .pc              (pc),
        .h               (h),
        .sv              (sv),
        .prediction      (prediction),
        .resolve_valid   (resolve_valid),
        .resolve_taken   (resolve_taken),
        .update          (update),
        .last_pc         (last_pc),
        .last_h          (last_h),
        .last_v          (last_v),
        .last_prediction (last_prediction),
        .br_outcome      (br_outcome),
        .mispredict      (mispredict),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .drop_cnt        (drop_cnt),
        .resolve_err     (resolve_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic mp, input logic [63:0] p,
                       input logic pr, input logic [31:0] hh,
                       input logic rv, input logic rt);
        make_prediction = mp;
        pc              = p;
        prediction      = pr;
        h               = hh;
        sv              = {6{hh}};
        resolve_valid   = rv;
        resolve_taken   = rt;
        @(posedge clk);
        #1;
        make_prediction = 1'b0;
        resolve_valid   = 1'b0;
    endtask

    task automatic push(input logic [63:0] p, input logic pr);
        cyc(1'b1, p, pr, p[31:0], 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic rt);
        cyc(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, rt);
    endtask

    logic [63:0] q_pc[$];
    logic        q_pr[$];
    logic [63:0] exp_pc;
    logic        exp_pr;

    initial begin
        rst_n = 1'b0;
        make_prediction = 1'b0;
        pc = '0; h = '0; sv = '0; prediction = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_update", 64'(update), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_last_pc", last_pc, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // In-order replay; 0x104 mispredicts and flushes 0x108.
        cyc(1'b1, 64'h100, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        cyc(1'b1, 64'h104, 1'b0, 32'hA5A5_0002, 1'b0, 1'b0);
        cyc(1'b1, 64'h108, 1'b1, 32'hA5A5_0003, 1'b0, 1'b0);
        chk("t1_count3", 64'(count), 64'd3);
        resolve(1'b1);
        chk("t1_upd0", 64'(update), 64'd1);
        chk("t1_pc0", last_pc, 64'h100);
        chk("t1_h0", 64'(last_h), 64'hA5A5_0001);
        chk("t1_v0", 64'(last_v == {6{32'hA5A5_0001}}), 64'd1);
        chk("t1_mis0", 64'(mispredict), 64'd0);
        chk("t1_cnt0", 64'(count), 64'd2);
        resolve(1'b1);
        chk("t1_pc1", last_pc, 64'h104);
        chk("t1_mis1", 64'(mispredict), 64'd1);
        chk("t1_lpred1", 64'(last_prediction), 64'd0);
        chk("t1_out1", 64'(br_outcome), 64'd1);
        chk("t1_cnt1", 64'(count), 64'd0);
        chk("t1_empty", 64'(empty), 64'd1);
        resolve(1'b1);
        chk("err_pulse", 64'(resolve_err), 64'd1);
        chk("err_upd", 64'(update), 64'd0);
        chk("err_cnt", 64'(count), 64'd0);
        chk("err_hold_pc", last_pc, 64'h104);
        cyc(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("err_once", 64'(resolve_err), 64'd0);

        // Fill, overflow, then pop+push while full.
        for (int i = 0; i < DEPTH; i++) push(64'h200 + 64'(4 * i), 1'b1);
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_cnt", 64'(count), 64'd16);
        push(64'h2FC, 1'b1);
        chk("t2_drop", 64'(drop_cnt), 64'd1);
        chk("t2_cnt_drop", 64'(count), 64'd16);
        cyc(1'b1, 64'h300, 1'b1, 32'h300, 1'b1, 1'b1);
        chk("t2_pp_pc", last_pc, 64'h200);
        chk("t2_pp_cnt", 64'(count), 64'd16);
        chk("t2_pp_drop", 64'(drop_cnt), 64'd1);
        for (int i = 1; i < DEPTH; i++) begin
            resolve(1'b1);
            chk("t2_drain", last_pc, 64'h200 + 64'(4 * i));
        end
        resolve(1'b1);
        chk("t2_tail", last_pc, 64'h300);
        chk("t2_empty", 64'(empty), 64'd1);

        // Flush with a same-cycle push that must be discarded.
        for (int i = 0; i < 5; i++) push(64'h400 + 64'(4 * i), 1'b0);
        cyc(1'b1, 64'h4F0, 1'b1, 32'h4F0, 1'b1, 1'b1);
        chk("t3_mis", 64'(mispredict), 64'd1);
        chk("t3_cnt", 64'(count), 64'd0);
        chk("t3_empty", 64'(empty), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd1);
        push(64'h500, 1'b1);
        resolve(1'b1);
        chk("t3_new_pc", last_pc, 64'h500);
        chk("t3_new_mis", 64'(mispredict), 64'd0);
        chk("t3_new_cnt", 64'(count), 64'd0);

        // Pointer wrap: 40 push/resolve pairs, count swinging 0..DEPTH.
        for (int r = 0; r < 3; r++) begin
            int n;
            n = (r == 1) ? 8 : DEPTH;
            for (int k = 0; k < n; k++) begin
                exp_pc = 64'h1000 + 64'(4 * (r * 100 + k));
                exp_pr = k[0];
                q_pc.push_back(exp_pc);
                q_pr.push_back(exp_pr);
                push(exp_pc, exp_pr);
            end
            chk("t4_cnt", 64'(count), 64'(n));
            for (int k = 0; k < n; k++) begin
                exp_pc = q_pc.pop_front();
                exp_pr = q_pr.pop_front();
                resolve(exp_pr);
                chk("t4_pc", last_pc, exp_pc);
                chk("t4_ok", {61'd0, update, mispredict, resolve_err},
                    64'b100);
            end
        end
        chk("t4_empty", 64'(empty), 64'd1);

        // Async reset between edges with an update pulse outstanding.
        for (int i = 0; i < 7; i++) push(64'h600 + 64'(4 * i), 1'b1);
        chk("t6_cnt7", 64'(count), 64'd7);
        resolve(1'b1);
        chk("t6_upd", 64'(update), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_upd", 64'(update), 64'd0);
        chk("t6_rst_cnt", 64'(count), 64'd0);
        chk("t6_rst_empty", 64'(empty), 64'd1);
        chk("t6_rst_pc", last_pc, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(64'h700, 1'b0);
        chk("t6_cnt1", 64'(count), 64'd1);
        resolve(1'b0);
        chk("t6_pc", last_pc, 64'h700);
        chk("t6_mis", 64'(mispredict), 64'd0);
        chk("t6_err", 64'(resolve_err), 64'd0);
        chk("t6_cnt0", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
